// File: rtl/bitcompare_arbiter.sv
// rtl/bitcompare_arbiter.sv - two-requester round-robin arbiter sharing one unsigned greater-than comparator
module bitcompare_arbiter #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 gt,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cmp_count,
    output logic [CNT_WIDTH-1:0] gt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             winner;
    logic             last_served;
    logic             win_sel;
    logic             any_req;
    logic             gt_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    assign any_req = req0 | req1;

    // On contention the requester that was not served last wins.
    always_comb begin
        win_sel = req1;
        if (req0 && req1) begin
            win_sel = ~last_served;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? CMP : IDLE;
            CMP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner      <= 1'b0;
            last_served <= 1'b1;
            opa         <= '0;
            opb         <= '0;
            gt_q        <= 1'b0;
            cmp_count   <= '0;
            gt_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner      <= win_sel;
                        last_served <= win_sel;
                        opa         <= win_sel ? a1 : a0;
                        opb         <= win_sel ? b1 : b0;
                    end
                end
                CMP: begin
                    gt_q <= (opa > opb);
                end
                DONE: begin
                    if (cmp_count != CNT_MAX) begin
                        cmp_count <= cmp_count + 1'b1;
                    end
                    if (gt_q && (gt_count != CNT_MAX)) begin
                        gt_count <= gt_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        gnt0  = (state == CMP)  && !winner;
        gnt1  = (state == CMP)  &&  winner;
        done0 = (state == DONE) && !winner;
        done1 = (state == DONE) &&  winner;
        busy  = (state != IDLE);
        gt    = gt_q;
    end

endmodule

// File: tb/tb_bitcompare_arbiter.sv
// tb/tb_bitcompare_arbiter.sv - scoreboard bench for bitcompare_arbiter
module tb_bitcompare_arbiter;

    localparam int W  = 10;
    localparam int CW = 8;

    typedef struct packed {
        logic id;
        logic gt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [W-1:0]  a0 = '0;
    logic [W-1:0]  b0 = '0;
    logic [W-1:0]  a1 = '0;
    logic [W-1:0]  b1 = '0;
    logic          gnt0, gnt1, done0, done1, gt, busy;
    logic [CW-1:0] cmp_count, gt_count;

    int   checks = 0;
    int   errors = 0;
    int   m_cmp = 0;
    int   m_gt = 0;
    bit   cnt_chk = 1'b0;
    exp_t sb[$];
    exp_t e;

    bitcompare_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .gt(gt), .busy(busy), .cmp_count(cmp_count), .gt_count(gt_count)
    );

    always #5 clk = ~clk;

    // Pops the expected result on every done pulse; checks counters one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_chk = 1'b0;
            m_cmp   = 0;
            m_gt    = 0;
        end else begin
            if (cnt_chk) begin
                checks++;
                if (cmp_count !== m_cmp[CW-1:0] || gt_count !== m_gt[CW-1:0]) begin
                    errors++;
                    $display("FAIL counters: cmp_count=%0d gt_count=%0d expected %0d %0d",
                             cmp_count, gt_count, m_cmp, m_gt);
                end
                cnt_chk = 1'b0;
            end
            if (done0 || done1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done0=%b done1=%b expected no done", done0, done1);
                end else begin
                    e = sb.pop_front();
                    if ((done0 && done1) || done1 !== e.id || gt !== e.gt) begin
                        errors++;
                        $display("FAIL result: done0=%b done1=%b gt=%b expected requester %0d gt=%b",
                                 done0, done1, gt, e.id, e.gt);
                    end
                    if (m_cmp < 255) m_cmp++;
                    if (e.gt && m_gt < 255) m_gt++;
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    task automatic run_one(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        @(posedge clk); #1;
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        sb.push_back('{id, (a > b)});
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (id ? done1 : done0) ok = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL txn_timeout: requester %0d got no done, expected done within 8 cycles", id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({gnt0, gnt1, done0, done1, gt, busy} !== 6'b0 || cmp_count !== 0 || gt_count !== 0) begin
            errors++;
            $display("FAIL reset_state: flags=%b cmp=%0d gt=%0d expected all 0",
                     {gnt0, gnt1, done0, done1, gt, busy}, cmp_count, gt_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        a0 = 10'h100; b0 = 10'h02B; req0 = 1'b1;
        sb.push_back('{1'b0, 1'b1});
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: gnt0=%b busy=%b expected 0 0", gnt0, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b busy=%b done0=%b expected 1 0 1 0", gnt0, gnt1, busy, done0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done0=%b gnt0=%b expected 1 0", done0, gnt0);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gt !== 1'b1 || cmp_count !== 8'd1 || gt_count !== 8'd1) begin
            errors++;
            $display("FAIL single_after: busy=%b gt=%b cmp=%0d gtc=%0d expected 0 1 1 1", busy, gt, cmp_count, gt_count);
        end
    endtask

    task automatic test_equal();
        run_one(1'b1, 10'h3FF, 10'h3FF);
        checks++;
        if (gt !== 1'b0 || cmp_count !== 8'd2 || gt_count !== 8'd1) begin
            errors++;
            $display("FAIL equal: gt=%b cmp=%0d gtc=%0d expected 0 2 1", gt, cmp_count, gt_count);
        end
    endtask

    task automatic test_operand_hold();
        @(posedge clk); #1;
        a0 = 10'h005; b0 = 10'h003; req0 = 1'b1;
        sb.push_back('{1'b0, 1'b1});
        repeat (2) @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL hold_gnt: gnt0=%b expected 1", gnt0);
        end
        a0 = 10'h000; b0 = 10'h3FF;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || gt !== 1'b1) begin
            errors++;
            $display("FAIL hold_result: done0=%b gt=%b expected 1 1", done0, gt);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_edges();
        run_one(1'b0, 10'h000, 10'h000);
        run_one(1'b1, 10'h000, 10'h001);
        run_one(1'b0, 10'h3FF, 10'h3FE);
        run_one(1'b1, 10'h3FE, 10'h3FF);
        run_one(1'b0, 10'h001, 10'h000);
        run_one(1'b1, 10'h200, 10'h1FF);
        // gt must stay stable through idle cycles with no request
        repeat (3) @(negedge clk);
        checks++;
        if (gt !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gt_stable: gt=%b busy=%b expected 1 0", gt, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_one(1'($urandom_range(0, 1)), W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)));
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d results pending expected 0", sb.size());
        end
    endtask

    task automatic test_abort();
        bit ok;
        @(posedge clk); #1;
        a0 = 10'h300; b0 = 10'h001; req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clk);
            if (gnt0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_gnt: gnt0 never seen expected 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, gt, busy} !== 6'b0 || cmp_count !== 0 || gt_count !== 0) begin
            errors++;
            $display("FAIL abort_reset: flags=%b cmp=%0d gtc=%0d expected all 0",
                     {gnt0, gnt1, done0, done1, gt, busy}, cmp_count, gt_count);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0 || busy) ok = 1'b1;
        end
        checks++;
        if (ok || cmp_count !== 0) begin
            errors++;
            $display("FAIL abort_after: activity=%b cmp=%0d expected 0 0", ok, cmp_count);
        end
    endtask

    task automatic test_contention();
        int n0;
        int n1;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a0 = 10'h000; b0 = 10'h001; a1 = 10'h200; b1 = 10'h081;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back('{1'b0, 1'b0});
        sb.push_back('{1'b1, 1'b1});
        sb.push_back('{1'b0, 1'b0});
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 30 && !(n0 == 2 && n1 == 1); i++) begin
            @(negedge clk);
            if (done1) begin n1++; req1 = 1'b0; end
            if (done0) begin n0++; if (n0 == 2) req0 = 1'b0; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n0 != 2 || n1 != 1 || sb.size() != 0 || cmp_count !== 8'd3 || gt_count !== 8'd1) begin
            errors++;
            $display("FAIL contention: n0=%0d n1=%0d pending=%0d cmp=%0d gtc=%0d expected 2 1 0 3 1",
                     n0, n1, sb.size(), cmp_count, gt_count);
        end
    endtask

    task automatic test_saturation();
        int n;
        int last;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a0 = 10'h2AA; b0 = 10'h155; req0 = 1'b1;
        for (int i = 0; i < 260; i++) sb.push_back('{1'b0, 1'b1});
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 900 && n < 260; cyc++) begin
            @(negedge clk);
            if (done0) begin
                n++;
                if (n > 1) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL back_to_back: spacing=%0d expected 3", cyc - last);
                    end
                end
                last = cyc;
                if (n == 260) req0 = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n != 260 || cmp_count !== 8'd255 || gt_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: n=%0d cmp=%0d gtc=%0d expected 260 255 255", n, cmp_count, gt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_equal();
        test_operand_hold();
        test_edges();
        test_random();
        test_abort();
        test_contention();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitcompare_arbiter.md
BITCOMPARE_ARBITER -- requirements
Module: bitcompare_arbiter

Interface
REQ-001 Parameter WIDTH, default 10, operand width in bits (unsigned).
REQ-002 Parameter CNT_WIDTH, default 8, width of statistics counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears immediately when low.
REQ-005 req0 / req1  input  1 each  compare request from requester 0 / 1, held high until done.
REQ-006 a0, b0 / a1, b1  input  WIDTH each  operand pair of requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1 each  requester's operands were latched; high for the CMP state.
REQ-008 done0 / done1  output  1 each  result valid for that requester; high for the DONE state.
REQ-009 gt  output  1  result of the last completed compare: 1 iff a > b, unsigned.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 cmp_count  output  CNT_WIDTH  number of completed compares, saturating.
REQ-012 gt_count  output  CNT_WIDTH  number of completed compares with gt=1, saturating.

Function
REQ-013 The block SHALL time-share one WIDTH-bit unsigned greater-than comparator between two requesters.
REQ-014 FSM states SHALL be IDLE, CMP, DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE: no req -> stay IDLE; any req -> select a winner, latch its a/b into internal opA/opB, go to CMP.
REQ-016 CMP: register gt_q <= (opA > opB), go to DONE unconditionally.
REQ-017 DONE: update counters, go to IDLE unconditionally.
REQ-018 gnt_i SHALL be 1 only while state = CMP and winner = i; done_i likewise for state = DONE.
REQ-019 Latency: req sampled at edge t0 -> gnt during cycle t0..t1 -> done and valid gt during cycle t1..t2.
REQ-020 Throughput: at most one compare per 3 cycles; a back-to-back request is sampled in the IDLE cycle after DONE.
REQ-021 Operands SHALL be sampled only at the IDLE->CMP edge; later changes to a/b SHALL NOT affect that result.
REQ-022 gt SHALL hold its value from DONE until the next compare's DONE; reads outside done are stale-but-stable.
REQ-023 Equal operands SHALL yield gt=0; a=0, b=0 SHALL yield gt=0; all-ones vs all-ones SHALL yield gt=0.
REQ-024 Arbitration SHALL be round-robin with a 1-bit last-served pointer, updated at each grant.
REQ-025 Single requester -> that requester wins regardless of pointer.
REQ-026 Both requesting -> the requester not equal to last-served wins.
REQ-027 A requester that still holds req in the IDLE cycle after its DONE SHALL be treated as a new request.
REQ-028 Requester protocol: deassert req during the cycle its done is high to avoid a repeat compare.
REQ-029 req changes during CMP/DONE SHALL be ignored; a req that drops before IDLE is never served.
REQ-030 cmp_count SHALL increment by 1 in DONE, and saturate at 2^CNT_WIDTH-1.
REQ-031 gt_count SHALL increment by 1 in DONE when gt_q=1, and saturate at 2^CNT_WIDTH-1.

Reset
REQ-032 reset low SHALL force state=IDLE, gnt0=gnt1=0, done0=done1=0, gt=0, busy=0, counters=0, last-served=1.
REQ-033 Last-served reset value 1 SHALL make requester 0 win the first simultaneous request.
REQ-034 Reset during CMP or DONE SHALL abort the transaction; no done pulse and no counter update for it.
REQ-035 After reset deasserts, the first edge SHALL evaluate requests as IDLE.

Verification
REQ-036 Reset check: reset=0 mid-run -> all outputs 0 immediately (asynchronously), counters 0.
REQ-037 Single request: req0=1, a0=0x100, b0=0x02B -> gnt0 next cycle, done0 following cycle, gt=1, cmp_count=1, gt_count=1.
REQ-038 Equality: req1=1, a1=b1=0x3FF -> done1 with gt=0; gt_count unchanged, cmp_count +1.
REQ-039 Contention after reset: req0 with a0=0x000 b0=0x001, and req1 with a1=0x200 b1=0x081, both held -> requester 0 first (gt=0), requester 1 next (gt=1); requester 0 served again only if still requesting, after requester 1.
REQ-040 Abort: assert reset while gnt0=1 -> no done0 ever pulses for it, state IDLE, cmp_count=0.
REQ-041 Saturation (CNT_WIDTH=8): 260 compares with a=0x2AA, b=0x155 -> cmp_count=255, gt_count=255.
